// File: rtl/check_flow.sv
// check_flow: overflow/underflow detector downstream of the counter stage.
// It compares counter_value with its one-clock-delayed copy to find wraps.
// Wrap events are reported as one-clock pulses and as sticky TSR status bits.
// TIER enables gate the TSR bits onto a single interrupt line.
// Optional build macro: CHECK_FLOW_IRQ_REG_EN.
//   Defined: irq comes from a flop loaded with the next-state tsr/tier.
//   Undefined: irq is combinational from the registered tsr/tier.
//   Both builds give the same cycle timing.
`timescale 1ns/1ps

module check_flow #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 check_flow_clk,
  input  logic                 check_flow_reset,
  input  logic [CNT_WIDTH-1:0] check_flow_cnt_value,
  input  logic [CNT_WIDTH-1:0] check_flow_cnt_last,
  input  logic                 check_flow_tcr_up_down,
  input  logic                 check_flow_tcr_enable,
  input  logic                 check_flow_tcr_load,
  input  logic                 check_flow_tsr_wr,
  input  logic [1:0]           check_flow_tsr_wdata,
  input  logic                 check_flow_tier_wr,
  input  logic [1:0]           check_flow_tier_wdata,
  output logic                 check_flow_ovf_pulse,
  output logic                 check_flow_udf_pulse,
  output logic [1:0]           check_flow_tsr,
  output logic [1:0]           check_flow_tier,
  output logic                 check_flow_irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  logic       r_load_d;
  logic       r_ovf_pulse;
  logic       r_udf_pulse;
  logic [1:0] r_tsr;
  logic [1:0] r_tier;

  logic       w_blk;
  logic       w_ovf_cond;
  logic       w_udf_cond;
  logic [1:0] w_tsr_cleared;
  logic [1:0] w_tsr_next;
  logic [1:0] w_tier_next;

  // A load jumps the counter arbitrarily.
  // Mask detection in the load clock and in the clock after it, while the delayed copy catches up.
  assign w_blk = check_flow_tcr_load | r_load_d;

  // A wrap only counts when it matches the current count direction.
  // A direction change mid-wrap is not an event.
  assign w_ovf_cond = (check_flow_cnt_last == CNT_MAX) && (check_flow_cnt_value == CNT_ZERO) &&
                      !check_flow_tcr_up_down && check_flow_tcr_enable && !w_blk;
  assign w_udf_cond = (check_flow_cnt_last == CNT_ZERO) && (check_flow_cnt_value == CNT_MAX) &&
                      check_flow_tcr_up_down && check_flow_tcr_enable && !w_blk;

  // Software writes of 0 clear a bit; a hardware set in the same clock overrides the clear.
  assign w_tsr_cleared = check_flow_tsr_wr ? (r_tsr & check_flow_tsr_wdata) : r_tsr;
  assign w_tsr_next    = w_tsr_cleared | {w_udf_cond, w_ovf_cond};
  assign w_tier_next   = check_flow_tier_wr ? check_flow_tier_wdata : r_tier;

  // Load-delay flop, event pulses and the status/enable registers.
  always_ff @(posedge check_flow_clk or posedge check_flow_reset) begin
    if (check_flow_reset) begin
      r_load_d    <= 1'b0;
      r_ovf_pulse <= 1'b0;
      r_udf_pulse <= 1'b0;
      r_tsr       <= 2'b00;
      r_tier      <= 2'b00;
    end else begin
      r_load_d    <= check_flow_tcr_load;
      r_ovf_pulse <= w_ovf_cond;
      r_udf_pulse <= w_udf_cond;
      r_tsr       <= w_tsr_next;
      r_tier      <= w_tier_next;
    end
  end

`ifdef CHECK_FLOW_IRQ_REG_EN
  logic r_irq;

  // Registered irq is built from next-state values.
  // It therefore rises and falls on the same edge as the tsr/tier bits that cause it.
  always_ff @(posedge check_flow_clk or posedge check_flow_reset) begin
    if (check_flow_reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_tsr_next & w_tier_next);
    end
  end

  assign check_flow_irq = r_irq;
`else
  assign check_flow_irq = |(r_tsr & r_tier);
`endif

  assign check_flow_ovf_pulse = r_ovf_pulse;
  assign check_flow_udf_pulse = r_udf_pulse;
  assign check_flow_tsr       = r_tsr;
  assign check_flow_tier      = r_tier;

endmodule
